// File: rtl/mem_xfer_dma.sv
// mem_xfer_dma: two DEPTH x DATA_W memories (A, B) plus a word-at-a-time
// copy engine that moves Len words from A to B, optionally inverting each
// word on the way. The host owns A (write/read) only while the engine is idle;
// B is host-readable at all times and written only by the engine.
module mem_xfer_dma #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  // host port, memory A
  input  logic              WEA,
  input  logic [ADDR_W-1:0] AddrA,
  input  logic [DATA_W-1:0] DataInA,
  output logic [DATA_W-1:0] DataOutA,
  // host read port, memory B
  input  logic [ADDR_W-1:0] AddrB,
  output logic [DATA_W-1:0] DataOutB,
  // transfer request
  input  logic              Start,
  input  logic [ADDR_W-1:0] SrcBase,
  input  logic [ADDR_W-1:0] DstBase,
  input  logic [ADDR_W:0]   Len,
  input  logic              Mode,
  // status
  output logic              Busy,
  output logic              Done
);

  localparam int DEPTH = 1 << ADDR_W;
  // Largest meaningful word count; anything above it is clamped.
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t stateReg;
  state_t stateNext;

  // Memories: plain arrays, no reset, so they map onto block RAM.
  logic [DATA_W-1:0] memA [DEPTH];
  logic [DATA_W-1:0] memB [DEPTH];

  // Transfer parameters captured on the accepted Start edge.
  logic [ADDR_W-1:0] srcReg;
  logic [ADDR_W-1:0] dstReg;
  logic [ADDR_W:0]   lenReg;
  logic              modeReg;

  // Engine datapath.
  logic [ADDR_W:0]   idxReg;
  logic [ADDR_W:0]   idxInc;
  logic [ADDR_W:0]   lenClamp;
  logic [ADDR_W-1:0] srcAddr;
  logic [ADDR_W-1:0] dstAddr;
  logic [DATA_W-1:0] dataReg;
  logic [DATA_W-1:0] wrData;

  logic isIdle;
  logic startAccept;
  logic hostWrite;
  logic engineWrite;

  assign isIdle      = (stateReg == IDLE);
  // Start and WEA are only honoured in IDLE; there is no request queue.
  assign startAccept = isIdle && Start;
  assign hostWrite   = isIdle && WEA;
  assign engineWrite = (stateReg == WR);

  assign lenClamp = (Len > LEN_MAX) ? LEN_MAX : Len;
  assign idxInc   = idxReg + IDX_ONE;

  // Addresses wrap at DEPTH simply by truncating to ADDR_W bits; source and
  // destination wrap independently of each other.
  assign srcAddr = srcReg + idxReg[ADDR_W-1:0];
  assign dstAddr = dstReg + idxReg[ADDR_W-1:0];

  // Per-bit conditional inversion of the word being moved.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_inv
      assign wrData[gi] = dataReg[gi] ^ modeReg;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic and status outputs.
  always_comb begin
    stateNext = stateReg;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (stateReg)
      IDLE: begin
        if (Start) begin
          stateNext = (lenClamp != '0) ? RD : FIN;
        end
      end
      RD: begin
        Busy      = 1'b1;
        stateNext = WR;
      end
      WR: begin
        Busy      = 1'b1;
        stateNext = (idxInc == lenReg) ? FIN : RD;
      end
      FIN: begin
        Done      = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Capture transfer parameters on an accepted Start; later changes on the
  // inputs do not disturb a running transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srcReg  <= '0;
      dstReg  <= '0;
      lenReg  <= '0;
      modeReg <= 1'b0;
    end else if (startAccept) begin
      srcReg  <= SrcBase;
      dstReg  <= DstBase;
      lenReg  <= lenClamp;
      modeReg <= Mode;
    end
  end

  // Word index: cleared on Start, advanced once per written word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idxReg <= '0;
    end else if (startAccept) begin
      idxReg <= '0;
    end else if (engineWrite) begin
      idxReg <= idxInc;
    end
  end

  // Host write into A, blocked while a transfer owns the memory.
  always_ff @(posedge clk) begin
    if (hostWrite) begin
      memA[AddrA] <= DataInA;
    end
  end

  // Host read of A: refreshed only in IDLE, held during a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DataOutA <= '0;
    end else if (isIdle) begin
      DataOutA <= memA[AddrA];
    end
  end

  // Engine read of A into the holding register during RD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataReg <= '0;
    end else if (stateReg == RD) begin
      dataReg <= memA[srcAddr];
    end
  end

  // Engine write into B during WR; reset forces IDLE so an aborted
  // transfer stops writing immediately.
  always_ff @(posedge clk) begin
    if (engineWrite) begin
      memB[dstAddr] <= wrData;
    end
  end

  // Host read of B every cycle; a same-edge engine write returns old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DataOutB <= '0;
    end else begin
      DataOutB <= memB[AddrB];
    end
  end

endmodule

// File: tb/tb_mem_xfer_dma.sv
// Directed testbench for mem_xfer_dma (DATA_W=8, ADDR_W=3).
module tb_mem_xfer_dma;

  logic       clk;
  logic       rst_n;
  logic       WEA;
  logic [2:0] AddrA;
  logic [7:0] DataInA;
  logic [7:0] DataOutA;
  logic [2:0] AddrB;
  logic [7:0] DataOutB;
  logic       Start;
  logic [2:0] SrcBase;
  logic [2:0] DstBase;
  logic [3:0] Len;
  logic       Mode;
  logic       Busy;
  logic       Done;

  int checks = 0;
  int errors = 0;

  logic [7:0] preA [8] = '{8'h23, 8'h87, 8'hB7, 8'hD7, 8'h11, 8'hC1, 8'h85, 8'h07};
  logic [7:0] expB [8];
  logic [7:0] gotB [8];
  logic [7:0] gotA [8];

  mem_xfer_dma #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .WEA      (WEA),
    .AddrA    (AddrA),
    .DataInA  (DataInA),
    .DataOutA (DataOutA),
    .AddrB    (AddrB),
    .DataOutB (DataOutB),
    .Start    (Start),
    .SrcBase  (SrcBase),
    .DstBase  (DstBase),
    .Len      (Len),
    .Mode     (Mode),
    .Busy     (Busy),
    .Done     (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [2:0] addr, input logic [7:0] data);
    WEA = 1'b1; AddrA = addr; DataInA = data;
    tick();
    WEA = 1'b0;
  endtask

  task automatic dump_a();
    for (int j = 0; j < 8; j++) begin
      AddrA = 3'(j);
      tick();
      gotA[j] = DataOutA;
    end
  endtask

  task automatic dump_b();
    for (int j = 0; j < 8; j++) begin
      AddrB = 3'(j);
      tick();
      gotB[j] = DataOutB;
    end
  endtask

  // Issue one Start, scramble the request inputs afterwards, and watch
  // Busy/Done for a bounded window. Cycle 1 is the cycle after the Start
  // edge. At injectCycle a host write of 0xFF to A[0] plus a Start is driven.
  task automatic run_xfer(input logic [2:0] src, input logic [2:0] dst,
                          input logic [3:0] len, input logic mode,
                          input int injectCycle,
                          output int busyCnt, output int firstBusy,
                          output int donePos, output int doneCnt);
    SrcBase = src; DstBase = dst; Len = len; Mode = mode; Start = 1'b1;
    tick();
    Start = 1'b0; SrcBase = ~src; DstBase = ~dst; Len = 4'd3; Mode = ~mode;
    busyCnt = 0; firstBusy = 0; donePos = 0; doneCnt = 0;
    for (int k = 1; k <= 24; k++) begin
      if (Busy) begin
        busyCnt++;
        if (firstBusy == 0) firstBusy = k;
      end
      if (Done) begin
        doneCnt++;
        if (donePos == 0) donePos = k;
      end
      WEA = 1'b0; Start = 1'b0;
      if (k == injectCycle) begin
        WEA = 1'b1; AddrA = 3'd0; DataInA = 8'hFF; Start = 1'b1;
      end
      tick();
    end
    WEA = 1'b0; Start = 1'b0;
    $display("xfer src=%0d dst=%0d len=%0d mode=%0d busy=%0d first=%0d done@%0d doneCnt=%0d",
             src, dst, len, mode, busyCnt, firstBusy, donePos, doneCnt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; WEA = 1'b0; AddrA = '0; DataInA = '0; AddrB = '0;
    Start = 1'b0; SrcBase = '0; DstBase = '0; Len = '0; Mode = 1'b0;
    #2;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: Busy=%b Done=%b, want 0 0", Busy, Done);
    end
    checks++;
    if (DataOutA !== 8'h00 || DataOutB !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: DataOutA=%h DataOutB=%h, want 00 00", DataOutA, DataOutB);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: Busy=%b Done=%b, want 0 0", Busy, Done);
    end
  endtask

  task automatic test_preload();
    for (int j = 0; j < 8; j++) write_a(3'(j), preA[j]);
    dump_a();
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (gotA[j] !== preA[j]) begin
        errors++;
        $display("FAIL preload_A[%0d]: got %h, want %h", j, gotA[j], preA[j]);
      end
    end
  endtask

  task automatic test_full_copy();
    int bc, fb, dp, dc;
    run_xfer(3'd0, 3'd0, 4'd8, 1'b0, 0, bc, fb, dp, dc);
    checks++;
    if (bc !== 16 || fb !== 1) begin
      errors++;
      $display("FAIL full_busy: cycles=%0d first=%0d, want 16 1", bc, fb);
    end
    checks++;
    if (dp !== 17 || dc !== 1) begin
      errors++;
      $display("FAIL full_done: at=%0d count=%0d, want 17 1", dp, dc);
    end
    expB = '{8'h23, 8'h87, 8'hB7, 8'hD7, 8'h11, 8'hC1, 8'h85, 8'h07};
    dump_b();
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (gotB[j] !== expB[j]) begin
        errors++;
        $display("FAIL full_B[%0d]: got %h, want %h", j, gotB[j], expB[j]);
      end
    end
  endtask

  task automatic test_wrap_invert();
    int bc, fb, dp, dc;
    run_xfer(3'd6, 3'd3, 4'd4, 1'b1, 0, bc, fb, dp, dc);
    checks++;
    if (bc !== 8 || dp !== 9 || dc !== 1) begin
      errors++;
      $display("FAIL wrap_timing: busy=%0d done@%0d count=%0d, want 8 9 1", bc, dp, dc);
    end
    expB = '{8'h23, 8'h87, 8'hB7, 8'h7A, 8'hF8, 8'hDC, 8'h78, 8'h07};
    dump_b();
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (gotB[j] !== expB[j]) begin
        errors++;
        $display("FAIL wrap_B[%0d]: got %h, want %h", j, gotB[j], expB[j]);
      end
    end
  endtask

  task automatic test_zero_len();
    int bc, fb, dp, dc;
    run_xfer(3'd2, 3'd5, 4'd0, 1'b1, 0, bc, fb, dp, dc);
    checks++;
    if (bc !== 0) begin
      errors++;
      $display("FAIL zero_busy: cycles=%0d, want 0", bc);
    end
    checks++;
    if (dp !== 1 || dc !== 1) begin
      errors++;
      $display("FAIL zero_done: at=%0d count=%0d, want 1 1", dp, dc);
    end
    dump_b();
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (gotB[j] !== expB[j]) begin
        errors++;
        $display("FAIL zero_B[%0d]: got %h, want %h", j, gotB[j], expB[j]);
      end
    end
  endtask

  task automatic test_clamp();
    int bc, fb, dp, dc;
    run_xfer(3'd0, 3'd0, 4'd9, 1'b1, 0, bc, fb, dp, dc);
    checks++;
    if (bc !== 16 || dp !== 17 || dc !== 1) begin
      errors++;
      $display("FAIL clamp_timing: busy=%0d done@%0d count=%0d, want 16 17 1", bc, dp, dc);
    end
    expB = '{8'hDC, 8'h78, 8'h48, 8'h28, 8'hEE, 8'h3E, 8'h7A, 8'hF8};
    dump_b();
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (gotB[j] !== expB[j]) begin
        errors++;
        $display("FAIL clamp_B[%0d]: got %h, want %h", j, gotB[j], expB[j]);
      end
    end
  endtask

  task automatic test_protection();
    int bc, fb, dp, dc;
    run_xfer(3'd0, 3'd0, 4'd8, 1'b0, 3, bc, fb, dp, dc);
    checks++;
    if (bc !== 16 || dp !== 17 || dc !== 1) begin
      errors++;
      $display("FAIL protect_timing: busy=%0d done@%0d count=%0d, want 16 17 1", bc, dp, dc);
    end
    dump_a();
    checks++;
    if (gotA[0] !== 8'h23) begin
      errors++;
      $display("FAIL protect_A0: got %h, want 23", gotA[0]);
    end
    expB = '{8'h23, 8'h87, 8'hB7, 8'hD7, 8'h11, 8'hC1, 8'h85, 8'h07};
    dump_b();
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (gotB[j] !== expB[j]) begin
        errors++;
        $display("FAIL protect_B[%0d]: got %h, want %h", j, gotB[j], expB[j]);
      end
    end
  endtask

  task automatic test_reset_midop();
    int bc, fb, dp, dc;
    int doneSeen;
    // Fill B with zeros by copying a zeroed A, then restore the A preload.
    for (int j = 0; j < 8; j++) write_a(3'(j), 8'h00);
    run_xfer(3'd0, 3'd0, 4'd8, 1'b0, 0, bc, fb, dp, dc);
    for (int j = 0; j < 8; j++) write_a(3'(j), preA[j]);
    // Prime the held read values: DataOutA <- A[1] at the Start edge.
    AddrA = 3'd1; AddrB = 3'd1;
    SrcBase = 3'd0; DstBase = 3'd0; Len = 4'd8; Mode = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    // Six more edges: three RD/WR pairs, B[0..2] written, now in RD.
    repeat (6) tick();
    checks++;
    if (Busy !== 1'b1 || DataOutA !== 8'h87 || DataOutB !== 8'h87) begin
      errors++;
      $display("FAIL midop_pre: Busy=%b DataOutA=%h DataOutB=%h, want 1 87 87",
               Busy, DataOutA, DataOutB);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || DataOutA !== 8'h00 || DataOutB !== 8'h00) begin
      errors++;
      $display("FAIL midop_reset: Busy=%b Done=%b DataOutA=%h DataOutB=%h, want 0 0 00 00",
               Busy, Done, DataOutA, DataOutB);
    end
    doneSeen = 0;
    repeat (3) begin
      tick();
      if (Done || Busy) doneSeen++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      if (Done || Busy) doneSeen++;
    end
    checks++;
    if (doneSeen !== 0) begin
      errors++;
      $display("FAIL midop_quiet: Done/Busy seen %0d cycles, want 0", doneSeen);
    end
    expB = '{8'h23, 8'h87, 8'hB7, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    dump_b();
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (gotB[j] !== expB[j]) begin
        errors++;
        $display("FAIL midop_B[%0d]: got %h, want %h", j, gotB[j], expB[j]);
      end
    end
    run_xfer(3'd0, 3'd0, 4'd8, 1'b0, 0, bc, fb, dp, dc);
    checks++;
    if (bc !== 16 || dp !== 17 || dc !== 1) begin
      errors++;
      $display("FAIL midop_restart: busy=%0d done@%0d count=%0d, want 16 17 1", bc, dp, dc);
    end
    expB = '{8'h23, 8'h87, 8'hB7, 8'hD7, 8'h11, 8'hC1, 8'h85, 8'h07};
    dump_b();
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (gotB[j] !== expB[j]) begin
        errors++;
        $display("FAIL restart_B[%0d]: got %h, want %h", j, gotB[j], expB[j]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_full_copy();
    test_wrap_invert();
    test_zero_len();
    test_clamp();
    test_protection();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
